fetch_ctrl: RTL
===============

# fetch_ctrl

Instruction-fetch sequencer that owns the program counter and drives the word-aligned read address of the instruction memory. It presents each fetched word to decode through a registered valid/ready stage. It applies branch/jump redirects from execute, flushing the in-flight word. It sits between the instruction memory (combinational read) and the decode stage of the CPU.

## Interface
- `n`, 32: instruction width in bits.
- `r`, 7: address width; the memory holds 2**r words and the PC is a word index.
- `HALT_WORD`, 32'hFFFFFFFF: encoding that stops fetch. Used only with `FETCH_HALT_EN`.
- `clk`  input  1  clock; all state updates on rising edge.
- `rst`  input  1  reset: synchronous, active-high.
- `readAddr`  output  r  word address to instruction memory; equals the PC register.
- `instr`  input  n  word returned by instruction memory for `readAddr`, same cycle.
- `branchEn`  input  1  redirect request, sampled each rising edge.
- `branchTarget`  input  r  word address to redirect to when `branchEn`=1.
- `outValid`  output  1  `outInstr`/`outPC` hold a valid fetched word.
- `outReady`  input  1  decode accepts the word this cycle.
- `outInstr`  output  n  registered fetched instruction.
- `outPC`  output  r  address the `outInstr` word was fetched from.
- `halted`  output  1  fetch has stopped on `HALT_WORD`. Tied 0 when `FETCH_HALT_EN` is undefined.

## Operation
- State: PC register `pc`, output register (`outValid`, `outInstr`, `outPC`), FSM {RUN, HALT}.
- `readAddr` = `pc`, combinationally. No other logic sits on that path.
- "Advance" = FSM in RUN and (`outValid`=0 or `outReady`=1).
- On advance without redirect, at the edge:
  - `outInstr` <= `instr`, `outPC` <= `pc`, `outValid` <= 1.
  - `pc` <= `pc`+1 modulo 2**r; 2**r-1 wraps to 0 silently.
- Output stage full and `outReady`=0: `pc` and the output registers hold. The word stays stable until accepted.
- Output stage accepted (`outReady`=1) with no advance possible (HALT): `outValid` <= 0.
- Redirect (`branchEn`=1) has priority over everything except `rst`:
  - `pc` <= `branchTarget`; `outValid` <= 0, discarding any unaccepted word.
  - FSM <= RUN.
  - `outReady` in the same cycle is still a legal accept of the current word. Decode owns squash of that word.
- HALT state (`FETCH_HALT_EN` only):
  - Entered at the edge where an advance latches `instr`==`HALT_WORD`. The halt word itself is presented with `outValid`=1.
  - In HALT, `pc` holds at halt address+1, no new fetch occurs, and `halted`=1.
  - Leaves HALT only on `branchEn` or `rst`.

## Timing
- Reset values: `pc`=0, `readAddr`=0, `outValid`=0, `outInstr`=0, `outPC`=0, `halted`=0, FSM=RUN.
- First word: edge 1 after `rst` falls latches word 0, so `outValid`=1 in the following cycle.
- Throughput: 1 word/cycle while `outReady`=1.
- Fetch latency: 1 cycle from PC to `outInstr`.
- Redirect: `branchEn` sampled at edge E gives `outValid`=0 after E. The word at `branchTarget` is valid after E+1.
- `rst` mid-stall, mid-redirect or in HALT: all state returns to reset values at that edge, and pending words are lost.
- `branchEn` and HALT entry in the same cycle: redirect wins, FSM stays RUN.

## Configuration
- `FETCH_HALT_EN` defined: HALT state, `HALT_WORD` compare and `halted` output are active.
- `FETCH_HALT_EN` undefined: FSM permanently RUN, `HALT_WORD` is treated as an ordinary instruction, and `halted` is tied 0.

## Test plan
- Sequential fetch: memory words 0..3 = 32'h11,22,33,44 with `outReady`=1 from reset release → four consecutive cycles show (`outPC`,`outInstr`) = (0,11),(1,22),(2,33),(3,44), no bubbles.
- Backpressure: `outReady`=0 for 3 cycles while word 2 is presented → `outInstr`=32'h33, `outPC`=2, `readAddr`=3 all stable. Releasing `outReady` → word 3 follows next cycle.
- Redirect flush: pulse `branchEn` with `branchTarget`=7'd40 while word 5 is unaccepted → next cycle `outValid`=0, `readAddr`=40. The cycle after that, `outPC`=40.
- Wrap-around: redirect to 127, then run → `outPC` sequence 127, 0, 1.
- Halt (`FETCH_HALT_EN`): word 6 = 32'hFFFFFFFF → word 6 is presented once, then `halted`=1, `outValid`=0 after accept, and `readAddr` stays 7. A `branchEn` to 0 resumes fetch from 0 with `halted`=0. Without the macro, fetch continues to word 7.
- Reset mid-run: assert `rst` while `outValid`=1 and `outReady`=0 → next cycle all outputs 0, and the fetch sequence restarts at address 0.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_if
// Bundle of every non-clock signal around the fetch sequencer: the
// instruction-memory read port, the redirect request from execute and the
// valid/ready stage towards decode.
//
// Parameters
//   n : instruction width in bits
//   r : word-address width (memory holds 2**r words)
//
// Signals (direction as seen by the fetch sequencer, modport master)
//   readAddr     out  r  word address to instruction memory
//   instr        in   n  word returned by memory for readAddr, same cycle
//   branchEn     in   1  redirect request from execute
//   branchTarget in   r  redirect word address
//   outValid     out  1  outInstr/outPC hold a valid fetched word
//   outReady     in   1  decode accepts the word this cycle
//   outInstr     out  n  registered fetched instruction
//   outPC        out  r  address outInstr was fetched from
//   halted       out  1  fetch stopped on the halt word
//
// The slave modport is the view of the surrounding system (memory, execute
// and decode together).
// ---------------------------------------------------------------------------
interface fetch_ctrl_if #(
    parameter int n = 32,
    parameter int r = 7
);
    logic [r-1:0] readAddr;
    logic [n-1:0] instr;
    logic         branchEn;
    logic [r-1:0] branchTarget;
    logic         outValid;
    logic         outReady;
    logic [n-1:0] outInstr;
    logic [r-1:0] outPC;
    logic         halted;

    modport master (
        output readAddr,
        input  instr,
        input  branchEn,
        input  branchTarget,
        output outValid,
        input  outReady,
        output outInstr,
        output outPC,
        output halted
    );

    modport slave (
        input  readAddr,
        output instr,
        output branchEn,
        output branchTarget,
        input  outValid,
        output outReady,
        input  outInstr,
        input  outPC,
        input  halted
    );
endinterface

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
// Instruction-fetch sequencer. Owns the program counter (a word index),
// drives it straight out as the instruction-memory read address, and
// registers each returned word into a valid/ready output stage for decode.
// A redirect from execute reloads the PC and drops any unaccepted word.
//
// Ports
//   clk  in   1  clock, all state updates on the rising edge
//   rst  in   1  synchronous active-high reset
//   bus  fetch_ctrl_if.master  memory, redirect and decode signals
//
// Parameters
//   n         instruction width (must match the bus instance)
//   r         address width (must match the bus instance)
//   HALT_WORD encoding that stops fetch (present only with FETCH_HALT_EN)
//
// Build option
//   FETCH_HALT_EN  when defined, latching HALT_WORD parks the sequencer in
//                  HALT until a redirect or reset, and bus.halted reports it.
//                  When undefined the FSM never leaves RUN, HALT_WORD is an
//                  ordinary instruction and bus.halted is tied low.
// ---------------------------------------------------------------------------
module fetch_ctrl #(
    parameter int n = 32,
    parameter int r = 7
`ifdef FETCH_HALT_EN
    ,
    parameter logic [n-1:0] HALT_WORD = 32'hFFFFFFFF
`endif
) (
    input logic          clk,
    input logic          rst,
    fetch_ctrl_if.master bus
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t       r_state;
    logic [r-1:0] r_pc;
    logic         r_outValid;
    logic [n-1:0] r_outInstr;
    logic [r-1:0] r_outPC;

    state_t       w_stateNext;
    logic [r-1:0] w_pcNext;
    logic         w_outValidNext;
    logic [n-1:0] w_outInstrNext;
    logic [r-1:0] w_outPCNext;
    logic         w_advance;
    logic         w_isHaltWord;

    // The memory address is the PC itself, with nothing in between, so the
    // memory's combinational read lands in the output stage one edge later.
    assign bus.readAddr = r_pc;
    assign bus.outValid = r_outValid;
    assign bus.outInstr = r_outInstr;
    assign bus.outPC    = r_outPC;

    // A new word may be latched only while running and when the output slot
    // is empty or being emptied by decode this very cycle.
    assign w_advance = (r_state == RUN) && (!r_outValid || bus.outReady);

`ifdef FETCH_HALT_EN
    assign w_isHaltWord = (bus.instr == HALT_WORD);
    assign bus.halted   = (r_state == HALT);
`else
    assign w_isHaltWord = 1'b0;
    assign bus.halted   = 1'b0;
`endif

    // State, PC and output-stage registers. Reset returns everything to the
    // power-on picture and throws away any pending word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_pc       <= '0;
            r_outValid <= 1'b0;
            r_outInstr <= '0;
            r_outPC    <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_pc       <= w_pcNext;
            r_outValid <= w_outValidNext;
            r_outInstr <= w_outInstrNext;
            r_outPC    <= w_outPCNext;
        end
    end

    // Next-state logic. Everything holds by default, which is exactly the
    // stall behaviour when the output slot is full and decode is not ready.
    // A redirect beats both fetch and halt entry; decode may still take the
    // current word in the redirect cycle, it simply disappears afterwards.
    // The PC increment relies on r-bit truncation to wrap the top word to 0.
    always_comb begin
        w_stateNext    = r_state;
        w_pcNext       = r_pc;
        w_outValidNext = r_outValid;
        w_outInstrNext = r_outInstr;
        w_outPCNext    = r_outPC;

        if (bus.branchEn) begin
            w_pcNext       = bus.branchTarget;
            w_outValidNext = 1'b0;
            w_stateNext    = RUN;
        end else if (w_advance) begin
            w_outInstrNext = bus.instr;
            w_outPCNext    = r_pc;
            w_outValidNext = 1'b1;
            w_pcNext       = r_pc + 1'b1;
            if (w_isHaltWord) begin
                w_stateNext = HALT;
            end
        end else if (bus.outReady) begin
            w_outValidNext = 1'b0;
        end
    end

endmodule
